// File: rtl/router_pkt_pkg.sv
// Shared flit-format definitions for the Aurora packetizer and de-packetizer.
package router_pkt_pkg;

    // Flit field layout: {payload, ttl, pkt_number, src_router}
    localparam int SRC_LSB        = 0;
    localparam int SRC_W          = 2;
    localparam int SEQ_LSB        = 2;
    localparam int SEQ_W          = 5;
    localparam int TTL_LSB        = 7;
    localparam int TTL_W          = 2;
    localparam int PAYLOAD_LSB    = 9;

    // Payload carried by flits 0..17 and by the shorter final flit 18
    localparam int FLIT_PAYLOAD_W = 55;
    localparam int LAST_PAYLOAD_W = 44;
    localparam int FMT_LSB        = PAYLOAD_LSB + LAST_PAYLOAD_W;

    localparam int NUMBER_PACKET  = 19;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // One-hot after prioritisation; at most one bit is set per flit
    typedef struct packed {
        logic seq;
        logic src;
        logic dup;
        logic fmt;
    } flit_err_t;

    typedef logic [NUMBER_PACKET-1:0] bitmap_t;

endpackage

// File: rtl/decode_packet_flit_hdr_check.sv
// Combinational flit header decode and validity checks against the
// current frame's received bitmap and latched source router.
module flit_hdr_check
    import router_pkt_pkg::*;
#(
    parameter int AURORA_DATA_WIDTH = 64
) (
    input  logic [AURORA_DATA_WIDTH-1:0] data,
    input  bitmap_t                      bitmap,
    input  logic [SRC_W-1:0]             src_latched,
    input  logic                         first,
    output logic [SEQ_W-1:0]             idx,
    output logic [SRC_W-1:0]             src,
    output logic [FLIT_PAYLOAD_W-1:0]    payload,
    output logic [LAST_PAYLOAD_W-1:0]    last_payload,
    output bitmap_t                      idx_onehot,
    output logic                         is_last,
    output logic                         accept,
    output flit_err_t                    err
);

    logic seq_bad;
    logic src_bad;
    logic dup_bad;
    logic fmt_bad;

    // TTL is carried on the link but has no meaning on the receive side
    logic [TTL_W-1:0] ttl_unused;
    assign ttl_unused = data[TTL_LSB +: TTL_W];

    // Field extraction, raw checks, then priority resolution seq > src > dup > fmt
    always_comb begin
        // NOTE: every output gets a default first so no path through this block can infer a latch.
        idx          = data[SEQ_LSB +: SEQ_W];
        src          = data[SRC_LSB +: SRC_W];
        payload      = data[PAYLOAD_LSB +: FLIT_PAYLOAD_W];
        last_payload = data[PAYLOAD_LSB +: LAST_PAYLOAD_W];
        idx_onehot   = bitmap_t'(1) << idx;
        is_last      = (idx == SEQ_W'(NUMBER_PACKET - 1));

        seq_bad = (idx >= SEQ_W'(NUMBER_PACKET));
        src_bad = !first && (src != src_latched);
        dup_bad = |(bitmap & idx_onehot);
        fmt_bad = is_last && (|data[AURORA_DATA_WIDTH-1:FMT_LSB]);

        err = '0;
        if (seq_bad) begin
            err.seq = 1'b1;
        end else if (src_bad) begin
            err.src = 1'b1;
        end else if (dup_bad) begin
            err.dup = 1'b1;
        end else if (fmt_bad) begin
            err.fmt = 1'b1;
        end

        // A format problem is reported but the flit is still used
        accept = !(seq_bad || src_bad || dup_bad);
    end

endmodule

// File: rtl/decode_packet.sv
// Reassembles 19 Aurora flits (any order) into one 1034-bit DFX frame and
// hands it to the decode controller over valid/ready.
module decode_packet
    import router_pkt_pkg::*;
#(
    parameter int DATA_WIDTH        = 1024,
    parameter int ADDR_WIDTH        = 10,
    parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
    parameter int NUMBER_PACKET     = 19,
    parameter int AURORA_DATA_WIDTH = 64,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pkt_valid,
    output logic                         pkt_ready,
    input  logic [AURORA_DATA_WIDTH-1:0] data_recv,
    output logic                         dfx_valid,
    input  logic                         dfx_ready,
    output logic [DATA_DFX_WIDTH-1:0]    data_dfx_recv,
    output logic [SRC_W-1:0]             src_router_out,
    output logic                         err_seq,
    output logic                         err_dup,
    output logic                         err_src,
    output logic                         err_fmt,
    output logic                         err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    state_t                    state;
    state_t                    next_state;
    bitmap_t                   bitmap;
    bitmap_t                   bitmap_set;
    logic [CNT_W-1:0]          idle_cnt;
    logic [SRC_W-1:0]          src_latched;
    logic [DATA_DFX_WIDTH-1:0] frame;

    logic                      fire;
    logic                      timeout_hit;
    logic                      process;
    logic                      write_en;
    logic                      complete;

    logic [SEQ_W-1:0]          idx;
    logic [SRC_W-1:0]          src;
    logic [FLIT_PAYLOAD_W-1:0] payload;
    logic [LAST_PAYLOAD_W-1:0] last_payload;
    bitmap_t                   idx_onehot;
    logic                      is_last;
    logic                      accept;
    flit_err_t                 err;

    flit_hdr_check #(
        .AURORA_DATA_WIDTH (AURORA_DATA_WIDTH)
    ) u_hdr (
        .data         (data_recv),
        .bitmap       (bitmap),
        .src_latched  (src_latched),
        .first        (state == IDLE),
        .idx          (idx),
        .src          (src),
        .payload      (payload),
        .last_payload (last_payload),
        .idx_onehot   (idx_onehot),
        .is_last      (is_last),
        .accept       (accept),
        .err          (err)
    );

    assign pkt_ready      = !rst && (state != DONE);
    assign dfx_valid      = (state == DONE);
    assign data_dfx_recv  = frame;
    assign src_router_out = src_latched;

    // A timeout wins over any flit presented in the same cycle
    assign fire        = pkt_valid && pkt_ready;
    assign timeout_hit = (state == COLLECT) && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign process     = fire && !timeout_hit;
    assign write_en    = process && accept;
    assign bitmap_set  = bitmap | idx_onehot;
    assign complete    = write_en && (&bitmap_set);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (write_en)    next_state = COLLECT;
            COLLECT: if (timeout_hit) next_state = IDLE;
                     else if (complete) next_state = DONE;
            DONE:    if (dfx_ready)   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Received bitmap and idle-cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap   <= '0;
            idle_cnt <= '0;
        end else if (state == DONE) begin
            idle_cnt <= '0;
            if (dfx_ready) begin
                bitmap <= '0;
            end
        end else if (timeout_hit) begin
            bitmap   <= '0;
            idle_cnt <= '0;
        end else if (fire) begin
            idle_cnt <= '0;
            if (write_en) begin
                bitmap <= bitmap_set;
            end
        end else if (state == COLLECT) begin
            idle_cnt <= idle_cnt + CNT_W'(1);
        end
    end

    // Source router is defined by the first flit that opens a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            src_latched <= '0;
        end else if ((state == IDLE) && write_en) begin
            src_latched <= src;
        end
    end

    // Frame register: each flit writes only its own slice
    always_ff @(posedge clk) begin
        // NOTE: the frame is a wide register, not a RAM, and its reset value is visible on the port, so it is reset.
        if (rst) begin
            frame <= '0;
        end else if (write_en) begin
            if (is_last) begin
                frame[DATA_DFX_WIDTH-1 -: LAST_PAYLOAD_W] <= last_payload;
            end
            for (int k = 0; k < NUMBER_PACKET - 1; k++) begin
                if (!is_last && (idx == SEQ_W'(k))) begin
                    frame[k*FLIT_PAYLOAD_W +: FLIT_PAYLOAD_W] <= payload;
                end
            end
        end
    end

    // Single-cycle error pulses, one cycle after the offending flit
    always_ff @(posedge clk) begin
        if (rst) begin
            err_seq     <= 1'b0;
            err_src     <= 1'b0;
            err_dup     <= 1'b0;
            err_fmt     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_seq     <= process && err.seq;
            err_src     <= process && err.src;
            err_dup     <= process && err.dup;
            err_fmt     <= process && err.fmt;
            err_timeout <= timeout_hit;
        end
    end

endmodule

// File: tb/tb_decode_packet.sv
// Scoreboard bench for decode_packet: a behavioural frame model predicts
// frames and error pulses; an independent monitor compares DUT outputs.
module tb_decode_packet;

    localparam int FW   = 1034;
    localparam int NP   = 19;
    localparam int TMO  = 1024;

    logic            clk = 1'b0;
    logic            rst;
    logic            pkt_valid;
    logic            pkt_ready;
    logic [63:0]     data_recv;
    logic            dfx_valid;
    logic            dfx_ready;
    logic [FW-1:0]   data_dfx_recv;
    logic [1:0]      src_router_out;
    logic            err_seq;
    logic            err_dup;
    logic            err_src;
    logic            err_fmt;
    logic            err_timeout;

    decode_packet dut (
        .clk            (clk),
        .rst            (rst),
        .pkt_valid      (pkt_valid),
        .pkt_ready      (pkt_ready),
        .data_recv      (data_recv),
        .dfx_valid      (dfx_valid),
        .dfx_ready      (dfx_ready),
        .data_dfx_recv  (data_dfx_recv),
        .src_router_out (src_router_out),
        .err_seq        (err_seq),
        .err_dup        (err_dup),
        .err_src        (err_src),
        .err_fmt        (err_fmt),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_frame(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        logic [54:0] g;
        logic [54:0] e;
        bit          shown;
        checks++;
        if (got !== exp) begin
            errors++;
            shown = 0;
            for (int i = 0; i < NP; i++) begin
                g = (i < NP - 1) ? got[i*55 +: 55] : {11'b0, got[FW-1 -: 44]};
                e = (i < NP - 1) ? exp[i*55 +: 55] : {11'b0, exp[FW-1 -: 44]};
                if (!shown && (g !== e)) begin
                    $display("FAIL %s slot %0d got=%h expected=%h", name, i, g, e);
                    shown = 1;
                end
            end
            if (!shown) $display("FAIL %s frame differs (unknown bits)", name);
        end
    endtask

    // ---------------- reference model ----------------
    // Error events as {seq, src, dup, fmt, timeout}
    localparam logic [4:0] EV_SEQ = 5'b10000;
    localparam logic [4:0] EV_SRC = 5'b01000;
    localparam logic [4:0] EV_DUP = 5'b00100;
    localparam logic [4:0] EV_FMT = 5'b00010;
    localparam logic [4:0] EV_TMO = 5'b00001;

    typedef struct {
        logic [FW-1:0] data;
        logic [1:0]    src;
    } frame_t;

    frame_t      frame_q[$];
    logic [4:0]  ev_q[$];

    logic [54:0] slot [NP];
    bit          got_slot [NP];
    int          n_got;
    bit          have_src;
    logic [1:0]  frame_src;

    function automatic void model_clear();
        for (int i = 0; i < NP; i++) got_slot[i] = 0;
        n_got    = 0;
        have_src = 0;
    endfunction

    function automatic void model_flit(input logic [63:0] f);
        int            k;
        logic [1:0]    s;
        frame_t        fr;
        k = int'(f[6:2]);
        s = f[1:0];
        if (k >= NP) begin
            ev_q.push_back(EV_SEQ);
            return;
        end
        if (have_src && (s != frame_src)) begin
            ev_q.push_back(EV_SRC);
            return;
        end
        if (got_slot[k]) begin
            ev_q.push_back(EV_DUP);
            return;
        end
        if (!have_src) begin
            have_src  = 1;
            frame_src = s;
        end
        got_slot[k] = 1;
        n_got++;
        if (k == NP - 1) begin
            slot[k] = {11'b0, f[52:9]};
            if (f[63:53] != 11'b0) ev_q.push_back(EV_FMT);
        end else begin
            slot[k] = f[63:9];
        end
        if (n_got == NP) begin
            fr.data = '0;
            for (int i = 0; i < NP - 1; i++) fr.data[i*55 +: 55] = slot[i];
            fr.data[FW-1 -: 44] = slot[NP-1][43:0];
            fr.src = frame_src;
            frame_q.push_back(fr);
            model_clear();
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [4:0] ev;
        frame_t     fr;
        if (!rst) begin
            if (dfx_valid && dfx_ready) begin
                if (frame_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected got a frame expected none");
                end else begin
                    fr = frame_q.pop_front();
                    check_frame("frame_data", data_dfx_recv, fr.data);
                    check("frame_src", 64'(src_router_out), 64'(fr.src));
                end
            end
            ev = {err_seq, err_src, err_dup, err_fmt, err_timeout};
            if (ev != 5'b0) begin
                if (ev_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL err_unexpected got=%b expected none", ev);
                end else begin
                    check("err_pulse", 64'(ev), 64'(ev_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    function automatic logic [63:0] mk_flit(input int k, input logic [1:0] s,
                                            input logic [54:0] p, input logic [1:0] ttl);
        return {p, ttl, 5'(k), s};
    endfunction

    function automatic logic [54:0] pat(input int k);
        return {11{5'(k)}};
    endfunction

    function automatic logic [54:0] rnd_payload(input int k);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return (k == NP - 1) ? {11'b0, r[43:0]} : r[54:0];
    endfunction

    // Presents one flit and holds it until accepted (bounded)
    task automatic send(input logic [63:0] f);
        int guard;
        guard     = 0;
        pkt_valid = 1'b1;
        data_recv = f;
        @(negedge clk);
        while (!pkt_ready) begin
            guard++;
            if (guard > 200) begin
                checks++;
                errors++;
                $display("FAIL send_accept got=no_accept expected=accept within 200 cycles");
                pkt_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk);
        model_flit(f);
        #1;
        pkt_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        pkt_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_dfx_valid", 64'(dfx_valid), 64'd0);
        check("rst_pkt_ready", 64'(pkt_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        frame_q.delete();
        @(negedge clk);
        check("post_rst_pkt_ready", 64'(pkt_ready), 64'd1);
        check("post_rst_dfx_valid", 64'(dfx_valid), 64'd0);
        check_frame("post_rst_data", data_dfx_recv, '0);
        check("post_rst_src", 64'(src_router_out), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain_check(input string tag);
        idle(4);
        check({tag, "_frames_left"}, 64'(frame_q.size()), 64'd0);
        check({tag, "_events_left"}, 64'(ev_q.size()), 64'd0);
    endtask

    // Random frame in shuffled order with optional bad flits mixed in
    task automatic random_frame(input bit inject);
        int          order [NP];
        int          j;
        int          tmp;
        logic [1:0]  s;
        logic [54:0] p;
        int          sent;
        s = 2'($urandom_range(3, 0));
        for (int i = 0; i < NP; i++) order[i] = i;
        for (int i = NP - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = order[i]; order[i] = order[j]; order[j] = tmp;
        end
        sent = 0;
        for (int i = 0; i < NP; i++) begin
            if (inject && ($urandom_range(3, 0) == 0)) begin
                case ($urandom_range(2, 0))
                    0: send(mk_flit($urandom_range(31, 19), s, rnd_payload(0), 2'($urandom)));
                    1: if (sent > 0) send(mk_flit(order[0], s, rnd_payload(0), 2'($urandom)));
                    default: if (sent > 0) send(mk_flit(order[i], s ^ 2'b01, rnd_payload(0), 2'($urandom)));
                endcase
            end
            p = rnd_payload(order[i]);
            if (inject && (order[i] == NP - 1) && $urandom_range(1, 0) == 1) p[54:44] = 11'($urandom);
            send(mk_flit(order[i], s, p, 2'($urandom)));
            sent++;
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [FW-1:0] ref_frame;
        logic [54:0]   p;

        rst       = 1'b1;
        pkt_valid = 1'b0;
        dfx_ready = 1'b1;
        data_recv = '0;
        model_clear();
        apply_reset();
        check("reset_err_vec", 64'({err_seq, err_src, err_dup, err_fmt, err_timeout}), 64'd0);

        // In-order frame with replicated-index payloads
        ref_frame = '0;
        for (int k = 0; k < NP - 1; k++) ref_frame[k*55 +: 55] = pat(k);
        ref_frame[FW-1 -: 44] = pat(NP - 1)[43:0];
        for (int k = 0; k < NP; k++) begin
            p = pat(k);
            if (k == NP - 1) p[54:44] = 11'b0;
            if (k == NP - 1) check("inorder_not_done_early", 64'(dfx_valid), 64'd0);
            send(mk_flit(k, 2'd2, p, 2'd3));
        end
        check("inorder_valid_latency", 64'(dfx_valid), 64'd1);
        check("inorder_ready_low", 64'(pkt_ready), 64'd0);
        check("inorder_slot0", 64'(data_dfx_recv[0 +: 55]), 64'(pat(0)));
        check("inorder_slot9", 64'(data_dfx_recv[9*55 +: 55]), 64'(pat(9)));
        check("inorder_slot17", 64'(data_dfx_recv[17*55 +: 55]), 64'(pat(17)));
        check("inorder_last", 64'(data_dfx_recv[FW-1 -: 44]), 64'(pat(18)[43:0]));
        check("inorder_src", 64'(src_router_out), 64'd2);
        drain_check("inorder");

        // Reverse order under backpressure, with a flit waiting during the hold
        dfx_ready = 1'b0;
        for (int k = NP - 1; k >= 0; k--) begin
            p = pat(k);
            if (k == NP - 1) p[54:44] = 11'b0;
            send(mk_flit(k, 2'd2, p, 2'd0));
        end
        pkt_valid = 1'b1;
        data_recv = mk_flit(3, 2'd2, 55'h1234, 2'd0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold_valid", 64'(dfx_valid), 64'd1);
            check("hold_ready", 64'(pkt_ready), 64'd0);
            check_frame("hold_data", data_dfx_recv, ref_frame);
        end
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
        dfx_ready = 1'b1;
        idle(2);
        check("release_valid", 64'(dfx_valid), 64'd0);
        check("release_ready", 64'(pkt_ready), 64'd1);
        drain_check("reverse");

        // Bad-sequence, duplicate and wrong-source flits, then complete the frame
        send(mk_flit(19, 2'd2, 55'h0, 2'd0));
        send(mk_flit(5, 2'd2, pat(5), 2'd0));
        send(mk_flit(5, 2'd2, ~pat(5), 2'd0));
        send(mk_flit(7, 2'd1, ~pat(7), 2'd0));
        check("errs_not_done", 64'(dfx_valid), 64'd0);
        for (int k = 0; k < NP; k++) begin
            if (k == 5) continue;
            p = pat(k);
            if (k == NP - 1) p[54:44] = 11'b0;
            send(mk_flit(k, 2'd2, p, 2'd1));
        end
        drain_check("errs");

        // Final flit with junk in the unused high bits
        for (int k = 0; k < NP - 1; k++) send(mk_flit(k, 2'd1, pat(k), 2'd0));
        p = {11'h7FF, 44'hABC_DEF0_1234};
        send(mk_flit(NP - 1, 2'd1, p, 2'd0));
        check("fmt_last_bits", 64'(data_dfx_recv[FW-1 -: 44]), 64'h0ABC_DEF0_1234);
        drain_check("fmt");

        // Partial frame abandoned by timeout, then a normal frame
        for (int k = 0; k < 10; k++) send(mk_flit(k, 2'd3, rnd_payload(k), 2'd0));
        ev_q.push_back(EV_TMO);
        model_clear();
        idle(TMO + 4);
        check("tmo_ready", 64'(pkt_ready), 64'd1);
        check("tmo_valid", 64'(dfx_valid), 64'd0);
        drain_check("timeout_pulse");
        random_frame(1'b0);
        drain_check("after_timeout");

        // Randomised frames with interleaved bad flits
        for (int n = 0; n < 6; n++) random_frame(1'b1);
        drain_check("random");

        // Reset in the middle of a frame
        for (int k = 0; k < 7; k++) send(mk_flit(k, 2'd0, rnd_payload(k), 2'd0));
        apply_reset();
        // Reset while a completed frame is held
        dfx_ready = 1'b0;
        random_frame(1'b0);
        idle(2);
        check("done_before_rst", 64'(dfx_valid), 64'd1);
        apply_reset();
        dfx_ready = 1'b1;
        random_frame(1'b0);
        drain_check("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog got=still_running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
